bpss_wr_arbiter: RTL and testbench
==================================

# bpss_wr_arbiter

Round-robin arbiter that shares one bypass write-request channel and its 512-bit host data stream among `N_REQ` bypass senders. Each sender issues chunk descriptors (vaddr, len, ctl, pid) plus the data beats of that chunk. The arbiter grants one sender per chunk, forwards that sender's descriptor, then forwards exactly `len` bytes of its data before re-arbitrating. It sits between the per-flow senders and the single bypass write port of the shell.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters; must be ≥2.
- `AXI_DATA_BITS`, 512: stream data width; beat bytes `BB = AXI_DATA_BITS/8`.
- `VADDR_BITS`, 48: virtual address width.
- `LEN_BITS`, 28: descriptor length width, in bytes.
- `PID_BITS`, 6: process ID width.

Ports:
- `aclk`, in, 1: clock.
- `aresetn`, in, 1: synchronous, active-low reset.
- `s_req_valid`, in, `N_REQ`: per-requester descriptor valid.
- `s_req_ready`, out, `N_REQ`: per-requester descriptor accept.
- `s_req_data`, in, `N_REQ*(VADDR_BITS+LEN_BITS+1+PID_BITS)`: packed descriptors, `{pid, ctl, len, vaddr}`; requester i occupies slice i.
- `s_axis_tvalid`, `s_axis_tready`, `s_axis_tlast`: in/out/in, `N_REQ` each; per-requester data handshake. `s_axis_tlast` is ignored.
- `s_axis_tdata`, in, `N_REQ*AXI_DATA_BITS`: packed data.
- `m_req_valid` out 1, `m_req_ready` in 1, `m_req_data` out `VADDR_BITS+LEN_BITS+1+PID_BITS`: shared descriptor output.
- `m_axis_tvalid` out 1, `m_axis_tready` in 1, `m_axis_tdata` out `AXI_DATA_BITS`, `m_axis_tkeep` out `BB`, `m_axis_tlast` out 1: shared data output.

## Operation
- FSM states: ST_IDLE, ST_REQ, ST_DATA.
- **ST_IDLE:** round-robin search over `s_req_valid`, starting at pointer `rr`.
  - Winner g gets `s_req_ready[g]=1` combinationally in the same cycle.
  - Capture descriptor, `grant=g`, `beats = len >> log2(BB)`, `rr=(g+1) mod N_REQ`; next state ST_REQ.
  - No valid request: stay, all `s_req_ready=0`.
- **ST_REQ:** `m_req_valid=1`, `m_req_data` = captured descriptor, held stable until `m_req_ready`.
  - On handshake, go to ST_DATA if `beats>0`, else to ST_IDLE.
- **ST_DATA:** combinational pass-through from requester `grant`.
  - `m_axis_tvalid=s_axis_tvalid[grant]`, `s_axis_tready[grant]=m_axis_tready`, `tdata` muxed.
  - All other `s_axis_tready=0`; `m_axis_tkeep` all ones.
  - Beat counter `cnt` increments per handshake.
  - `m_axis_tlast=1` exactly when `cnt==beats-1`; the input tlast is never forwarded.
  - Handshake on the last beat goes to ST_IDLE (see Configuration).
- `len` must be a multiple of `BB`; the low `log2(BB)` bits are dropped, so `len<BB` means zero beats.
- Only one `s_req_ready` bit is ever high, and only in ST_IDLE. At most one `s_axis_tready` bit is ever high, and only in ST_DATA.
- **Simultaneous requests:** the lowest index at or after `rr` (modulo `N_REQ`) wins.

## Timing
- Reset: state ST_IDLE, `rr=0`, `cnt=0`, `grant=0`.
  - All `s_req_ready`, `s_axis_tready`, `m_req_valid`, `m_axis_tvalid`, `m_axis_tlast` = 0.
  - `m_req_data` and `m_axis_tdata` = 0.
- Reset asserted mid-chunk aborts the chunk; no partial-chunk state survives.
- Descriptor latency: `s_req` handshake in cycle T gives `m_req_valid` in T+1.
- Data throughput: 1 beat/cycle in ST_DATA, zero added latency.
- Minimum overhead is 2 cycles per chunk (IDLE + REQ) when `m_req_ready` is held high.
- `m_req_valid`, once high, stays high with stable data until the handshake.

## Configuration
- `BPSS_ARB_STICKY_EN` defined: after the last beat of a chunk whose captured `ctl==0`, the FSM returns to ST_IDLE but arbitration is locked to `grant`.
  - Only `s_req_valid[grant]` is considered and `rr` is not advanced.
  - The lock releases after a chunk with `ctl==1` completes; a whole transfer goes out contiguously.
- Not defined: plain per-chunk round-robin; `ctl` has no effect on arbitration.

## Test plan
- **Single chunk:** requester 1 sends `len=256`, `ctl=1`, `vaddr=0x1000`, `pid=3`, with 4 beats D0..D3 → one `m_req` `{3,1,256,0x1000}`; 4 output beats D0..D3, tlast on D3 only; `rr=2`.
- **All four request simultaneously** with `len=64` each, sinks always ready → grants in order 0,1,2,3, each 3 cycles apart (IDLE, REQ, 1 DATA beat).
- **Backpressure:** `m_req_ready` low for 5 cycles → `m_req_valid` and data held stable; `m_axis_tready` toggling 1/0 during 8 beats → no beat lost or duplicated, tlast on beat 8.
- **Zero length:** `len=32` (<BB) → `m_req` forwarded, no data beats, back to ST_IDLE the cycle after the handshake, `s_axis_tready` never high.
- **Sticky:** requester 0 issues chunks ctl=0,0,1 while requester 2 is pending → with `BPSS_ARB_STICKY_EN`: 0,0,0,2; without: 0,2,0,…
- **Reset in ST_DATA** after 2 of 4 beats → all outputs 0 next cycle, `rr=0`; a fresh request is served normally.

Source files
------------

// File: rtl/bpss_wr_arbiter.sv
// rtl/bpss_wr_arbiter.sv - round-robin arbiter sharing one bypass write request/data channel among N_REQ senders
// Optional feature macro: BPSS_ARB_STICKY_EN (hold the grant until a ctl==1 chunk completes).
module bpss_wr_arbiter #(
    parameter int N_REQ         = 4,
    parameter int AXI_DATA_BITS = 512,
    parameter int VADDR_BITS    = 48,
    parameter int LEN_BITS      = 28,
    parameter int PID_BITS      = 6
) (
    input  logic                                                  aclk,
    input  logic                                                  aresetn,
    input  logic [N_REQ-1:0]                                      s_req_valid,
    output logic [N_REQ-1:0]                                      s_req_ready,
    input  logic [N_REQ*(VADDR_BITS+LEN_BITS+1+PID_BITS)-1:0]     s_req_data,
    input  logic [N_REQ-1:0]                                      s_axis_tvalid,
    output logic [N_REQ-1:0]                                      s_axis_tready,
    input  logic [N_REQ-1:0]                                      s_axis_tlast,
    input  logic [N_REQ*AXI_DATA_BITS-1:0]                        s_axis_tdata,
    output logic                                                  m_req_valid,
    input  logic                                                  m_req_ready,
    output logic [VADDR_BITS+LEN_BITS+1+PID_BITS-1:0]             m_req_data,
    output logic                                                  m_axis_tvalid,
    input  logic                                                  m_axis_tready,
    output logic [AXI_DATA_BITS-1:0]                              m_axis_tdata,
    output logic [AXI_DATA_BITS/8-1:0]                            m_axis_tkeep,
    output logic                                                  m_axis_tlast
);
    localparam int DESC_W  = VADDR_BITS + LEN_BITS + 1 + PID_BITS;
    localparam int BB      = AXI_DATA_BITS / 8;
    localparam int BB_LOG2 = $clog2(BB);
    localparam int IDX_W   = $clog2(N_REQ);
    localparam int CTL_POS = VADDR_BITS + LEN_BITS;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam logic [LEN_BITS-1:0] LEN_ONE = LEN_BITS'(1);

    logic [1:0]          state_q, state_d;
    logic [IDX_W-1:0]    rr_q, rr_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic [LEN_BITS-1:0] beats_q, beats_d;
    logic [LEN_BITS-1:0] cnt_q, cnt_d;
    logic [DESC_W-1:0]   desc_q, desc_d;

    logic                win_found;
    logic [IDX_W-1:0]    win_idx;
    logic [DESC_W-1:0]   win_desc;
    logic                chunk_done;
    logic                lock_active;
    logic                data_hs;
    logic                last_beat;
    logic                unused_tlast;

    logic [DESC_W-1:0]        req_desc  [N_REQ];
    logic [AXI_DATA_BITS-1:0] req_tdata [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign req_desc[g]  = s_req_data[g*DESC_W +: DESC_W];
        assign req_tdata[g] = s_axis_tdata[g*AXI_DATA_BITS +: AXI_DATA_BITS];
    end

    // Sender-side tlast is untrusted; chunk boundaries come only from the descriptor length.
    assign unused_tlast = ^s_axis_tlast;

`ifdef BPSS_ARB_STICKY_EN
    logic lock_q, lock_d;

    assign lock_active = lock_q;

    always_comb begin
        lock_d = lock_q;
        if (chunk_done) begin
            lock_d = ~desc_q[CTL_POS];
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end
`else
    assign lock_active = 1'b0;
`endif

    // While locked only the current owner may win; otherwise first valid at or after rr wins.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        if (lock_active) begin
            win_found = s_req_valid[grant_q];
            win_idx   = grant_q;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                idx = int'(rr_q) + k;
                if (idx >= N_REQ) begin
                    idx = idx - N_REQ;
                end
                if (!win_found && s_req_valid[IDX_W'(idx)]) begin
                    win_found = 1'b1;
                    win_idx   = IDX_W'(idx);
                end
            end
        end
    end

    assign win_desc  = req_desc[win_idx];
    assign last_beat = (cnt_q == beats_q - LEN_ONE);
    assign data_hs   = m_axis_tvalid && m_axis_tready;

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        grant_d    = grant_q;
        beats_d    = beats_q;
        cnt_d      = cnt_q;
        desc_d     = desc_q;
        chunk_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    desc_d  = win_desc;
                    grant_d = win_idx;
                    beats_d = win_desc[VADDR_BITS +: LEN_BITS] >> BB_LOG2;
                    cnt_d   = '0;
                    if (!lock_active) begin
                        rr_d = (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + 1'b1;
                    end
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (m_req_ready) begin
                    if (beats_q != '0) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d    = ST_IDLE;
                        chunk_done = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (data_hs) begin
                    cnt_d = cnt_q + LEN_ONE;
                    if (last_beat) begin
                        cnt_d      = '0;
                        state_d    = ST_IDLE;
                        chunk_done = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            rr_q    <= '0;
            grant_q <= '0;
            beats_q <= '0;
            cnt_q   <= '0;
            desc_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            beats_q <= beats_d;
            cnt_q   <= cnt_d;
            desc_q  <= desc_d;
        end
    end

    always_comb begin
        s_req_ready   = '0;
        s_axis_tready = '0;
        if (state_q == ST_IDLE && win_found) begin
            s_req_ready[win_idx] = 1'b1;
        end
        if (state_q == ST_DATA) begin
            s_axis_tready[grant_q] = m_axis_tready;
        end
    end

    assign m_req_valid   = (state_q == ST_REQ);
    assign m_req_data    = desc_q;
    assign m_axis_tvalid = (state_q == ST_DATA) && s_axis_tvalid[grant_q];
    assign m_axis_tdata  = (state_q == ST_DATA) ? req_tdata[grant_q] : '0;
    assign m_axis_tkeep  = '1;
    assign m_axis_tlast  = (state_q == ST_DATA) && last_beat;

endmodule

// File: tb/tb_bpss_wr_arbiter.sv
// tb/tb_bpss_wr_arbiter.sv - self-checking bench for bpss_wr_arbiter
module tb_bpss_wr_arbiter;
    localparam int N_REQ  = 4;
    localparam int DW     = 512;
    localparam int VA     = 48;
    localparam int LW     = 28;
    localparam int PW     = 6;
    localparam int DESC_W = VA + LW + 1 + PW;
    localparam int BB     = DW / 8;

    logic                      aclk = 1'b0;
    logic                      aresetn = 1'b0;
    logic [N_REQ-1:0]          s_req_valid;
    logic [N_REQ-1:0]          s_req_ready;
    logic [N_REQ*DESC_W-1:0]   s_req_data;
    logic [N_REQ-1:0]          s_axis_tvalid;
    logic [N_REQ-1:0]          s_axis_tready;
    logic [N_REQ-1:0]          s_axis_tlast;
    logic [N_REQ*DW-1:0]       s_axis_tdata;
    logic                      m_req_valid;
    logic                      m_req_ready;
    logic [DESC_W-1:0]         m_req_data;
    logic                      m_axis_tvalid;
    logic                      m_axis_tready;
    logic [DW-1:0]             m_axis_tdata;
    logic [BB-1:0]             m_axis_tkeep;
    logic                      m_axis_tlast;

    bpss_wr_arbiter #(
        .N_REQ(N_REQ), .AXI_DATA_BITS(DW), .VADDR_BITS(VA), .LEN_BITS(LW), .PID_BITS(PW)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_data(s_req_data),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tdata(s_axis_tdata),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_data(m_req_data),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast)
    );

    initial forever #5 aclk = ~aclk;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int beats_seen = 0;
    int tready_cycles = 0;
    logic tog_mode = 1'b0;

    logic [DESC_W-1:0] dq   [N_REQ][$];
    logic [DW-1:0]     bq   [N_REQ][$];
    logic [DESC_W-1:0] pend [N_REQ][$];
    logic [DESC_W-1:0] exp_desc[$];
    logic [DW-1:0]     exp_beat[$];
    logic              exp_last[$];
    int                mreq_cyc[$];
    int                sreq_cyc[$];

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event not expected by model", name);
    endtask

    function automatic logic [DESC_W-1:0] mk_desc(input int pid, input int ctl, input int len, input logic [VA-1:0] va);
        return {PW'(pid), 1'(ctl), LW'(len), va};
    endfunction

    function automatic logic [DW-1:0] dgen(input int r, input logic [VA-1:0] va, input int k);
        logic [31:0] w;
        w = {va[23:0], 4'(r), 4'(k)};
        return {16{w}};
    endfunction

    task automatic push_chunk(input int r, input logic [VA-1:0] va, input int len, input int ctl, input int pid);
        logic [DESC_W-1:0] d;
        d = mk_desc(pid, ctl, len, va);
        dq[r].push_back(d);
        pend[r].push_back(d);
        for (int k = 0; k < len / BB; k++) bq[r].push_back(dgen(r, va, k));
    endtask

    // Model: the next granted chunk of requester r yields its descriptor then len/BB beats, last one tagged.
    task automatic expect_grant(input int r);
        logic [DESC_W-1:0] d;
        int nb;
        d  = pend[r].pop_front();
        nb = int'(d[VA +: LW]) / BB;
        exp_desc.push_back(d);
        for (int k = 0; k < nb; k++) begin
            exp_beat.push_back(dgen(r, d[VA-1:0], k));
            exp_last.push_back(k == nb - 1);
        end
    endtask

    function automatic bit all_idle();
        bit e;
        e = (exp_desc.size() == 0) && (exp_beat.size() == 0);
        for (int r = 0; r < N_REQ; r++) e = e && (dq[r].size() == 0) && (bq[r].size() == 0);
        return e;
    endfunction

    task automatic flush();
        for (int r = 0; r < N_REQ; r++) begin
            dq[r].delete();
            bq[r].delete();
            pend[r].delete();
        end
        exp_desc.delete();
        exp_beat.delete();
        exp_last.delete();
    endtask

    task automatic tick();
        @(posedge aclk);
        #2;
        if (tog_mode) m_axis_tready = ~m_axis_tready;
    endtask

    task automatic wait_done(input string name);
        int i;
        i = 0;
        while (i < 400 && !all_idle()) begin
            tick();
            i++;
        end
        tick();
        check({name, "_drained"}, all_idle(), 1);
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        m_req_ready = 1'b1;
        m_axis_tready = 1'b1;
        tog_mode = 1'b0;
        flush();
        tick();
        tick();
        aresetn = 1'b1;
        mreq_cyc.delete();
        sreq_cyc.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_s_req_ready"}, s_req_ready, 0);
        check({tag, "_s_axis_tready"}, s_axis_tready, 0);
        check({tag, "_m_req_valid"}, m_req_valid, 0);
        check({tag, "_m_axis_tvalid"}, m_axis_tvalid, 0);
        check({tag, "_m_axis_tlast"}, m_axis_tlast, 0);
        check({tag, "_m_req_data"}, m_req_data, 0);
        check({tag, "_m_axis_tdata"}, m_axis_tdata, 0);
    endtask

    initial forever begin
        @(posedge aclk);
        cyc++;
    end

    // Sender models: each requester offers the head of its descriptor and beat queues.
    initial begin
        s_req_valid = '0;
        s_req_data = '0;
        s_axis_tvalid = '0;
        s_axis_tdata = '0;
        s_axis_tlast = '0;
        forever begin
            @(negedge aclk);
            for (int r = 0; r < N_REQ; r++) begin
                if (aresetn && s_req_valid[r] && s_req_ready[r] && dq[r].size() > 0) void'(dq[r].pop_front());
                if (aresetn && s_axis_tvalid[r] && s_axis_tready[r] && bq[r].size() > 0) void'(bq[r].pop_front());
            end
            @(posedge aclk);
            #1;
            for (int r = 0; r < N_REQ; r++) begin
                s_req_valid[r] = dq[r].size() > 0;
                s_req_data[r*DESC_W +: DESC_W] = (dq[r].size() > 0) ? dq[r][0] : '0;
                s_axis_tvalid[r] = bq[r].size() > 0;
                s_axis_tlast[r] = bq[r].size() > 0;
                s_axis_tdata[r*DW +: DW] = (bq[r].size() > 0) ? bq[r][0] : '0;
            end
        end
    end

    initial begin
        logic stall_prev;
        logic [DESC_W-1:0] prev_desc;
        stall_prev = 1'b0;
        prev_desc = '0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                stall_prev = 1'b0;
                continue;
            end
            if (|s_axis_tready) tready_cycles++;
            if (|s_axis_tready && exp_beat.size() == 0) fail("s_axis_tready_without_data");
            if ($countones(s_req_ready) > 1) fail("multiple_s_req_ready");
            if ($countones(s_axis_tready) > 1) fail("multiple_s_axis_tready");
            if (stall_prev) begin
                check("m_req_valid_held", m_req_valid, 1);
                check("m_req_data_held", m_req_data, prev_desc);
            end
            stall_prev = m_req_valid && !m_req_ready;
            prev_desc = m_req_data;
            if (|(s_req_valid & s_req_ready)) sreq_cyc.push_back(cyc);
            if (m_req_valid && m_req_ready) begin
                mreq_cyc.push_back(cyc);
                if (exp_desc.size() == 0) fail("unexpected_m_req");
                else check("m_req_data", m_req_data, exp_desc.pop_front());
            end
            if (m_axis_tvalid && m_axis_tready) begin
                beats_seen++;
                check("m_axis_tkeep", m_axis_tkeep, {BB{1'b1}});
                if (exp_beat.size() == 0) fail("unexpected_beat");
                else begin
                    check("m_axis_tdata", m_axis_tdata, exp_beat.pop_front());
                    check("m_axis_tlast", m_axis_tlast, exp_last.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, i;
        m_req_ready = 1'b1;
        m_axis_tready = 1'b1;
        tick();
        tick();
        @(negedge aclk);
        check_all_zero("reset");
        tick();
        aresetn = 1'b1;

        // Single chunk from requester 1, then 0 and 2 together: rr must now point at 2.
        b0 = beats_seen;
        push_chunk(1, 48'h1000, 256, 1, 3);
        expect_grant(1);
        i = 0;
        @(negedge aclk);
        while (!m_req_valid && i < 20) begin
            @(negedge aclk);
            i++;
        end
        check("single_desc_literal", m_req_data, {6'd3, 1'b1, 28'd256, 48'h1000});
        wait_done("single");
        check("single_beats", beats_seen - b0, 4);
        check("desc_latency", mreq_cyc[0] - sreq_cyc[0], 1);
        push_chunk(0, 48'h2000, 64, 1, 0);
        push_chunk(2, 48'h3000, 64, 1, 1);
        expect_grant(2);
        expect_grant(0);
        wait_done("rr_after_single");

        // All four at once from rr=0.
        do_reset();
        for (int r = 0; r < N_REQ; r++) push_chunk(r, 48'h10000 + 48'(r * 'h40), 64, 1, r);
        for (int r = 0; r < N_REQ; r++) expect_grant(r);
        wait_done("all_four");
        check("all_four_count", mreq_cyc.size(), 4);
        for (int k = 1; k < 4; k++) check("all_four_spacing", mreq_cyc[k] - mreq_cyc[k-1], 3);

        // Descriptor stall then toggling data sink.
        do_reset();
        m_req_ready = 1'b0;
        push_chunk(2, 48'h4000, 512, 1, 5);
        expect_grant(2);
        repeat (7) tick();
        @(negedge aclk);
        check("stall_valid", m_req_valid, 1);
        tick();
        m_req_ready = 1'b1;
        tog_mode = 1'b1;
        b0 = beats_seen;
        wait_done("backpressure");
        check("backpressure_beats", beats_seen - b0, 8);
        tog_mode = 1'b0;
        m_axis_tready = 1'b1;

        // Zero-length chunk.
        do_reset();
        b0 = beats_seen;
        i = tready_cycles;
        push_chunk(0, 48'h5000, 32, 1, 2);
        expect_grant(0);
        wait_done("zero_len");
        check("zero_len_no_tready", tready_cycles - i, 0);
        check("zero_len_no_beats", beats_seen - b0, 0);
        mreq_cyc.delete();
        sreq_cyc.delete();
        push_chunk(1, 48'h5100, 32, 1, 2);
        push_chunk(2, 48'h6000, 64, 1, 4);
        expect_grant(1);
        expect_grant(2);
        wait_done("zero_len_pair");
        check("zero_len_idle_next", sreq_cyc[1] - mreq_cyc[0], 1);

        // Transfer of ctl=0,0,1 chunks from requester 0 with requester 2 pending.
        do_reset();
        push_chunk(0, 48'h7000, 64, 0, 1);
        push_chunk(0, 48'h7100, 64, 0, 1);
        push_chunk(0, 48'h7200, 64, 1, 1);
        push_chunk(2, 48'h8000, 64, 1, 2);
`ifdef BPSS_ARB_STICKY_EN
        expect_grant(0);
        expect_grant(0);
        expect_grant(0);
        expect_grant(2);
`else
        expect_grant(0);
        expect_grant(2);
        expect_grant(0);
        expect_grant(0);
`endif
        wait_done("sticky");

        // Reset after two of four beats, then 1 and 3 together must pick 1 (rr back at 0).
        do_reset();
        push_chunk(2, 48'h9000, 256, 1, 7);
        expect_grant(2);
        b0 = beats_seen;
        i = 0;
        while (beats_seen - b0 < 2 && i < 30) begin
            tick();
            i++;
        end
        check("reset_mid_beats", beats_seen - b0, 2);
        aresetn = 1'b0;
        m_axis_tready = 1'b0;
        flush();
        tick();
        @(negedge aclk);
        check_all_zero("mid_reset");
        tick();
        aresetn = 1'b1;
        m_axis_tready = 1'b1;
        push_chunk(1, 48'hA000, 64, 1, 1);
        push_chunk(3, 48'hB000, 64, 1, 2);
        expect_grant(1);
        expect_grant(3);
        wait_done("after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
